// File: rtl/checker_query_engine_pkg.sv
// Shared types and constants for the checker query engine: FSM states,
// LFSR feedback taps and the default seed.
package checker_query_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST1,
        ST_RST2,
        ST_RUN,
        ST_DONE
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/checker_query_engine_lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR with synchronous load and step.
module lfsr16
    import checker_query_engine_pkg::*;
#(
    parameter logic [15:0] RST_VAL = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/checker_query_engine.sv
// Drives identical LFSR stimulus into a locked and an oracle FSM instance and
// reports the first vector whose responses differ.
module checker_query_engine
    import checker_query_engine_pkg::*;
#(
    parameter int          X_W      = 10,
    parameter int          Y_W      = 11,
    parameter int          LEN_W    = 8,
    parameter logic [15:0] SEED_DEF = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [LEN_W-1:0] len,
    input  logic             key_val,
    output logic [X_W-1:0]   x_out,
    output logic             key_out,
    output logic             dut_rst,
    input  logic [Y_W-1:0]   y_lock,
    input  logic [Y_W-1:0]   y_orac,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [LEN_W-1:0] mismatch_idx,
    output logic [Y_W-1:0]   mismatch_vec,
    output state_t           dbg_state
);

    // Host handshake: start is a request taken only while busy is low; each
    // accepted start yields exactly one done pulse, and mismatch/mismatch_idx/
    // mismatch_vec are valid from that pulse until the next accepted start.

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic             key_q;
    logic [15:0]      lfsr_val;
    logic [15:0]      seed_eff;
    logic             start_acc;
    logic             resp_diff;
    logic             last_vec;
    logic             lfsr_step;
    logic             lfsr_unused;

    assign seed_eff    = (seed == 16'h0000) ? SEED_DEF : seed;
    assign resp_diff   = (y_lock != y_orac);
    assign last_vec    = (idx_q == len_q - 1'b1);
    assign lfsr_unused = ^lfsr_val[15:X_W];

    lfsr16 #(.RST_VAL(SEED_DEF)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_acc),
        .step  (lfsr_step),
        .seed  (seed_eff),
        .value (lfsr_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RST1;
                end
            end
            ST_RST1: state_d = ST_RST2;
            ST_RST2: state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (resp_diff || last_vec) begin
                    state_d = ST_DONE;
                end else begin
                    lfsr_step = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_out     = (state_q == ST_RUN) ? lfsr_val[X_W-1:0] : '0;
        dut_rst   = (state_q == ST_RST1) || (state_q == ST_RST2);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        key_out   = key_q;
        dbg_state = state_q;
    end

    // Run context and result registers; results persist past DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q        <= '0;
            idx_q        <= '0;
            key_q        <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
            mismatch_vec <= '0;
        end else begin
            if (start_acc) begin
                len_q        <= len;
                key_q        <= key_val;
                mismatch     <= 1'b0;
                mismatch_idx <= '0;
                mismatch_vec <= '0;
            end
            if (state_q == ST_RST2) begin
                idx_q <= '0;
            end else if (lfsr_step) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == ST_RUN && resp_diff) begin
                mismatch     <= 1'b1;
                mismatch_idx <= idx_q;
                mismatch_vec <= y_lock ^ y_orac;
            end
        end
    end

endmodule

// File: tb/tb_checker_query_engine.sv
// Directed bench for checker_query_engine with negedge-committing responder
// models standing in for the locked and oracle FSM instances.
module tb_checker_query_engine;
  import checker_query_engine_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [7:0]  len;
  logic        key_val;
  logic [9:0]  x_out;
  logic        key_out;
  logic        dut_rst;
  logic [10:0] y_lock;
  logic [10:0] y_orac;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [7:0]  mismatch_idx;
  logic [10:0] mismatch_vec;
  state_t      dbg_state;

  checker_query_engine dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .len          (len),
    .key_val      (key_val),
    .x_out        (x_out),
    .key_out      (key_out),
    .dut_rst      (dut_rst),
    .y_lock       (y_lock),
    .y_orac       (y_orac),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .mismatch_idx (mismatch_idx),
    .mismatch_vec (mismatch_vec),
    .dbg_state    (dbg_state)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // scoreboard
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] prev_q[$];
  logic       got_key_q[$];
  int         done_cyc;
  int         rst_cyc;
  bit         got_done;

  // responder models: both commit on the falling edge
  bit force_en  = 1'b0;
  int force_idx = 0;
  int vcnt      = 0;

  always @(negedge clk) begin
    logic [10:0] base;
    base = {^x_out, x_out};
    y_lock <= base;
    y_orac <= base ^ ((force_en && vcnt == force_idx) ? 11'h008 : 11'h000);
    if (!busy || dut_rst) vcnt <= 0;
    else if (!done) vcnt <= vcnt + 1;
  end

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic build_exp(input logic [15:0] s, input int n);
    logic [15:0] v;
    exp_q.delete();
    v = (s == 16'h0000) ? 16'hACE1 : s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v[9:0]);
      v = ref_next(v);
    end
  endtask

  // driver tasks
  task automatic launch(input logic [15:0] s, input logic [7:0] l, input logic k);
    @(negedge clk);
    seed    = s;
    len     = l;
    key_val = k;
    start   = 1'b1;
    @(posedge clk);
  endtask

  task automatic collect(input int budget, input bit pulse);
    got_q.delete();
    got_key_q.delete();
    got_done = 1'b0;
    done_cyc = 0;
    rst_cyc  = 0;
    for (int c = 1; c <= budget && !got_done; c++) begin
      @(negedge clk);
      if (pulse && busy && !dut_rst && !done) start = ~start;
      else start = 1'b0;
      if (dut_rst) rst_cyc++;
      if (busy && !dut_rst && !done) begin
        got_q.push_back(x_out);
        got_key_q.push_back(key_out);
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = c;
      end
    end
    total_cnt++;
    if (!got_done) $display("FAIL run_timeout: done not seen within %0d cycles", budget);
    else pass_cnt++;
  endtask

  task automatic check_seq(input string name);
    total_cnt++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_len: got %0d vectors, expected %0d", name, got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_x[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; seed = '0; len = '0; key_val = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({x_out, key_out, dut_rst, busy, done, mismatch, mismatch_idx, mismatch_vec} !== '0)
      $display("FAIL reset_outputs: got x=%h key=%b drst=%b busy=%b done=%b mm=%b idx=%h vec=%h, expected all 0",
               x_out, key_out, dut_rst, busy, done, mismatch, mismatch_idx, mismatch_vec);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0)
      $display("FAIL reset_idle: got state=%0d busy=%b, expected IDLE busy=0", dbg_state, busy);
    else pass_cnt++;
  endtask

  task automatic test_identical();
    force_en = 1'b0;
    build_exp(16'h0000, 8);
    launch(16'h0000, 8'd8, 1'b0);
    collect(40, 1'b0);
    total_cnt++;
    if (done_cyc !== 11) $display("FAIL ident_done_cycle: got %0d, expected 11", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (mismatch !== 1'b0) $display("FAIL ident_mismatch: got %b, expected 0", mismatch);
    else pass_cnt++;
    check_seq("ident");
  endtask

  task automatic test_mismatch();
    force_en  = 1'b1;
    force_idx = 5;
    build_exp(16'h0000, 6);
    launch(16'h0000, 8'd20, 1'b1);
    collect(60, 1'b0);
    total_cnt++;
    if (done_cyc !== 9) $display("FAIL mm_done_cycle: got %0d, expected 9", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({mismatch, mismatch_idx, mismatch_vec} !== {1'b1, 8'd5, 11'h008})
      $display("FAIL mm_result: got mm=%b idx=%0d vec=%h, expected mm=1 idx=5 vec=008",
               mismatch, mismatch_idx, mismatch_vec);
    else pass_cnt++;
    check_seq("mm");
    @(negedge clk);
    total_cnt++;
    if ({busy, mismatch, mismatch_idx, mismatch_vec} !== {1'b0, 1'b1, 8'd5, 11'h008})
      $display("FAIL mm_hold: got busy=%b mm=%b idx=%0d vec=%h, expected busy=0 mm=1 idx=5 vec=008",
               busy, mismatch, mismatch_idx, mismatch_vec);
    else pass_cnt++;
    force_en = 1'b0;
  endtask

  task automatic test_len_zero();
    exp_q.delete();
    launch(16'h0042, 8'd0, 1'b0);
    collect(20, 1'b0);
    total_cnt++;
    if (rst_cyc !== 2) $display("FAIL len0_rst_cycles: got %0d, expected 2", rst_cyc);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc !== 3) $display("FAIL len0_done_cycle: got %0d, expected 3", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (mismatch !== 1'b0) $display("FAIL len0_mismatch_cleared: got %b, expected 0", mismatch);
    else pass_cnt++;
    check_seq("len0");
  endtask

  task automatic test_back_to_back();
    build_exp(16'h00FF, 4);
    launch(16'h00FF, 8'd4, 1'b0);
    collect(40, 1'b1);
    total_cnt++;
    if (done_cyc !== 7) $display("FAIL b2b_pulsed_done_cycle: got %0d, expected 7", done_cyc);
    else pass_cnt++;
    check_seq("b2b_first");
    start = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b, expected 0", busy);
    else pass_cnt++;
    @(posedge clk);
    collect(40, 1'b0);
    total_cnt++;
    if ({rst_cyc, done_cyc} !== {32'd2, 32'd7})
      $display("FAIL b2b_second_run: got rst=%0d done=%0d, expected rst=2 done=7", rst_cyc, done_cyc);
    else pass_cnt++;
    check_seq("b2b_second");
  endtask

  task automatic test_reset_mid_run();
    launch(16'h5A5A, 8'd10, 1'b1);
    got_q.delete();
    for (int c = 0; c < 30 && got_q.size() < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && !dut_rst && !done) got_q.push_back(x_out);
    end
    total_cnt++;
    if (got_q.size() !== 4) $display("FAIL midrst_reach_v3: got %0d vectors, expected 4", got_q.size());
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({x_out, key_out, dut_rst, busy, done, mismatch, mismatch_idx, mismatch_vec} !== '0)
      $display("FAIL midrst_outputs: got x=%h key=%b drst=%b busy=%b done=%b mm=%b, expected all 0",
               x_out, key_out, dut_rst, busy, done, mismatch);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    build_exp(16'h5A5A, 10);
    launch(16'h5A5A, 8'd10, 1'b1);
    collect(40, 1'b0);
    total_cnt++;
    if (done_cyc !== 13) $display("FAIL midrst_rerun_done: got %0d, expected 13", done_cyc);
    else pass_cnt++;
    check_seq("midrst_rerun");
  endtask

  task automatic test_key();
    int bad;
    build_exp(16'h1234, 3);
    launch(16'h1234, 8'd3, 1'b1);
    collect(30, 1'b0);
    bad = 0;
    foreach (got_key_q[i]) if (got_key_q[i] !== 1'b1) bad++;
    total_cnt++;
    if (bad != 0 || got_key_q.size() != 3)
      $display("FAIL key1_follow: got %0d bad of %0d, expected 0 bad of 3", bad, got_key_q.size());
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() < 1 || got_q[0] !== 10'h234)
      $display("FAIL key_first_vec: got %h, expected 234", (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    else pass_cnt++;
    check_seq("key1");
    prev_q = got_q;
    launch(16'h1234, 8'd3, 1'b0);
    collect(30, 1'b0);
    bad = 0;
    foreach (got_key_q[i]) if (got_key_q[i] !== 1'b0) bad++;
    total_cnt++;
    if (bad != 0 || got_key_q.size() != 3)
      $display("FAIL key0_follow: got %0d bad of %0d, expected 0 bad of 3", bad, got_key_q.size());
    else pass_cnt++;
    exp_q = prev_q;
    check_seq("key0_same_seq");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identical();
    test_mismatch();
    test_len_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_key();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
